// File: rtl/fetch_buffer_u_pkg.sv
// Shared definitions for the fetch buffer: NOP encoding, FSM states, pointer
// sizing and a saturating adder used by the optional perf counters.
package fetch_buffer_u_pkg;

    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_WAIT  = 2'd1,
        ST_FULL  = 2'd2
    } fetch_state_t;

    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[32] ? '1 : sum[31:0];
    endfunction

endpackage

// File: rtl/fetch_buffer_u_queue.sv
// Circular prefetch queue: DEPTH entries of {instruction, pc} with push, pop
// and single-cycle clear; head is a combinational read at the read pointer.
module fetch_queue
    import fetch_buffer_u_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_clear,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic [XLEN-1:0]            i_ir,
    input  logic [XLEN-1:0]            i_pc,
    output logic [XLEN-1:0]            o_head_ir,
    output logic [XLEN-1:0]            o_head_pc,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int unsigned PW = ptr_width(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [XLEN-1:0] r_ir_mem [DEPTH];
    logic [XLEN-1:0] r_pc_mem [DEPTH];
    logic [PW-1:0]   r_rd_ptr;
    logic [PW-1:0]   r_wr_ptr;
    logic [CW-1:0]   r_count;

    // Storage needs no reset: nothing is visible until count says so.
    always_ff @(posedge clk) begin
        if (i_push && !i_clear) begin
            r_ir_mem[r_wr_ptr] <= i_ir;
            r_pc_mem[r_wr_ptr] <= i_pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (i_clear) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (i_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head_ir = r_ir_mem[r_rd_ptr];
    assign o_head_pc = r_pc_mem[r_rd_ptr];
    assign o_count   = r_count;

endmodule

// File: rtl/fetch_buffer_u.sv
// Instruction-fetch unit with a DEPTH-entry prefetch queue, wait-state and
// redirect handling. Optional perf counters are built when FETCH_PERF_EN is defined.
module fetch_buffer_u
    import fetch_buffer_u_pkg::*;
#(
    parameter int unsigned      XLEN     = 32,
    parameter int unsigned      DEPTH    = 4,
    parameter logic [XLEN-1:0]  RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    output logic [XLEN-1:0]            iad,
    input  logic [XLEN-1:0]            idt,
    input  logic                       acki_n,
    input  logic                       redirect,
    input  logic [XLEN-1:0]            redirect_pc,
    input  logic                       stall,
    output logic                       ir_valid,
    output logic [XLEN-1:0]            ir,
    output logic [XLEN-1:0]            pc,
    output logic [XLEN-1:0]            pc4,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [31:0]                perf_wait_cnt,
    output logic [31:0]                perf_flush_cnt
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [XLEN-1:0] r_fetch_pc;
    fetch_state_t    r_state;

    logic [XLEN-1:0] w_head_ir;
    logic [XLEN-1:0] w_head_pc;
    logic [CW-1:0]   w_count;
    logic            w_valid;
    logic            w_room;
    logic            w_pop;
    logic            w_push;
    logic [XLEN-1:0] w_redirect_target;

    assign w_valid           = (w_count != '0);
    assign w_room            = (w_count < CW'(DEPTH));
    assign w_pop             = w_valid & ~stall & ~redirect;
    assign w_push            = ~redirect & ~acki_n & (w_room | w_pop);
    assign w_redirect_target = redirect_pc & ~XLEN'(3);

    fetch_queue #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clear   (redirect),
        .i_push    (w_push),
        .i_pop     (w_pop),
        .i_ir      (idt),
        .i_pc      (r_fetch_pc),
        .o_head_ir (w_head_ir),
        .o_head_pc (w_head_pc),
        .o_count   (w_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_pc <= RESET_PC;
        end else if (redirect) begin
            r_fetch_pc <= w_redirect_target;
        end else if (w_push) begin
            r_fetch_pc <= r_fetch_pc + XLEN'(4);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_FETCH;
        end else if (redirect) begin
            r_state <= ST_FETCH;
        end else begin
            case (r_state)
                ST_FETCH: begin
                    if (acki_n)               r_state <= ST_WAIT;
                    else if (!w_room && !w_pop) r_state <= ST_FULL;
                end
                ST_WAIT: begin
                    if (w_push) r_state <= ST_FETCH;
                end
                ST_FULL: begin
                    if (w_pop) r_state <= ST_FETCH;
                end
                default: r_state <= ST_FETCH;
            endcase
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] r_perf_wait_cnt;
    logic [31:0] r_perf_flush_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_wait_cnt  <= '0;
            r_perf_flush_cnt <= '0;
        end else begin
            if (r_state == ST_WAIT) r_perf_wait_cnt  <= sat_add32(r_perf_wait_cnt, 32'd1);
            if (redirect)           r_perf_flush_cnt <= sat_add32(r_perf_flush_cnt, 32'(w_count));
        end
    end

    assign perf_wait_cnt  = r_perf_wait_cnt;
    assign perf_flush_cnt = r_perf_flush_cnt;
`else
    assign perf_wait_cnt  = '0;
    assign perf_flush_cnt = '0;
`endif

    assign iad      = r_fetch_pc;
    assign ir_valid = w_valid;
    assign ir       = w_valid ? w_head_ir : XLEN'(NOP_INSN);
    assign pc       = w_valid ? w_head_pc : '0;
    assign pc4      = w_valid ? (w_head_pc + XLEN'(4)) : '0;
    assign count    = w_count;

endmodule

// File: tb/tb_fetch_buffer_u.sv
// Scoreboard bench for fetch_buffer_u: a reference queue model predicts the head
// entry, count, fetch address and perf counters each cycle.
module tb_fetch_buffer_u;
    import fetch_buffer_u_pkg::*;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 4;
`ifdef FETCH_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [XLEN-1:0] iad;
    logic [XLEN-1:0] idt = '0;
    logic            acki_n = 1'b1;
    logic            redirect = 1'b0;
    logic [XLEN-1:0] redirect_pc = '0;
    logic            stall = 1'b0;
    logic            ir_valid;
    logic [XLEN-1:0] ir;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
    logic [2:0]      count;
    logic [31:0]     perf_wait_cnt;
    logic [31:0]     perf_flush_cnt;

    always #5 clk = ~clk;

    fetch_buffer_u #(
        .XLEN     (XLEN),
        .DEPTH    (DEPTH),
        .RESET_PC (32'h0000_0000)
    ) u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .iad            (iad),
        .idt            (idt),
        .acki_n         (acki_n),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .stall          (stall),
        .ir_valid       (ir_valid),
        .ir             (ir),
        .pc             (pc),
        .pc4            (pc4),
        .count          (count),
        .perf_wait_cnt  (perf_wait_cnt),
        .perf_flush_cnt (perf_flush_cnt)
    );

    typedef struct packed {
        logic [31:0] ir;
        logic [31:0] pc;
    } entry_t;

    entry_t       sb[$];
    logic [31:0]  m_pc;
    fetch_state_t m_state;
    logic [31:0]  m_wait;
    logic [31:0]  m_flush;
    int           n_vec = 0;
    int           n_err = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A3C, a[31:16]} + 32'h0000_0100;
    endfunction

    function automatic logic [31:0] exp_ir();
        return (sb.size() != 0) ? sb[0].ir : 32'h0000_0013;
    endfunction

    function automatic logic [31:0] exp_pc();
        return (sb.size() != 0) ? sb[0].pc : 32'h0;
    endfunction

    function automatic logic [31:0] exp_pc4();
        return (sb.size() != 0) ? sb[0].pc + 32'd4 : 32'h0;
    endfunction

    task automatic model_reset();
        sb.delete();
        m_pc    = 32'h0;
        m_state = ST_FETCH;
        m_wait  = '0;
        m_flush = '0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0; acki_n = 1'b1; stall = 1'b0; redirect = 1'b0;
        model_reset();
        @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    // One clock: drive at negedge, update the model at posedge, return at posedge+1.
    task automatic step(input logic a, input logic s, input logic r, input logic [31:0] rpc);
        logic   v, room, pop, push;
        entry_t e;
        @(negedge clk);
        acki_n = a; stall = s; redirect = r; redirect_pc = rpc;
        idt  = a ? 32'hDEAD_BEEF : mem_word(m_pc);
        v    = (sb.size() != 0);
        room = (sb.size() < DEPTH);
        pop  = v & ~s & ~r;
        push = ~r & ~a & (room | pop);
        @(posedge clk);
        if (m_state == ST_WAIT) m_wait = m_wait + 32'd1;
        if (r) begin
            m_flush = m_flush + 32'(sb.size());
            sb.delete();
            m_pc    = rpc & ~32'h3;
            m_state = ST_FETCH;
        end else begin
            case (m_state)
                ST_FETCH: if (a) m_state = ST_WAIT; else if (!room && !pop) m_state = ST_FULL;
                ST_WAIT:  if (push) m_state = ST_FETCH;
                ST_FULL:  if (pop) m_state = ST_FETCH;
                default:  m_state = ST_FETCH;
            endcase
            if (pop) void'(sb.pop_front());
            if (push) begin
                e.ir = mem_word(m_pc);
                e.pc = m_pc;
                sb.push_back(e);
                m_pc = m_pc + 32'd4;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        step(1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        #2 rst_n = 1'b0;
        #1;
        n_vec++; if (count !== 3'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", count); end
        n_vec++; if (ir_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", ir_valid); end
        n_vec++; if (ir !== 32'h0000_0013) begin n_err++; $display("FAIL reset_ir: got %h want 00000013", ir); end
        n_vec++; if (pc !== 32'h0 || pc4 !== 32'h0) begin n_err++; $display("FAIL reset_pc: got %h/%h want 0/0", pc, pc4); end
        n_vec++; if (iad !== 32'h0) begin n_err++; $display("FAIL reset_iad: got %h want 0", iad); end
        n_vec++; if (perf_wait_cnt !== 32'h0 || perf_flush_cnt !== 32'h0) begin n_err++; $display("FAIL reset_perf: got %h/%h want 0/0", perf_wait_cnt, perf_flush_cnt); end
        model_reset();
        acki_n = 1'b1; stall = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic test_stream();
        apply_reset();
        n_vec++; if (iad !== 32'h0) begin n_err++; $display("FAIL stream_iad0: got %h want 0", iad); end
        for (int k = 1; k <= 3; k++) begin
            step(1'b0, 1'b0, 1'b0, 32'h0);
            n_vec++; if (iad !== 32'(4 * k)) begin n_err++; $display("FAIL stream_iad: got %h want %h", iad, 32'(4 * k)); end
            n_vec++; if (ir_valid !== 1'b1 || pc !== 32'(4 * (k - 1))) begin n_err++; $display("FAIL stream_head: got v=%b pc=%h want v=1 pc=%h", ir_valid, pc, 32'(4 * (k - 1))); end
            n_vec++; if (pc4 !== 32'(4 * k) || ir !== exp_ir()) begin n_err++; $display("FAIL stream_ir: got pc4=%h ir=%h want pc4=%h ir=%h", pc4, ir, 32'(4 * k), exp_ir()); end
        end
    endtask

    task automatic test_full();
        apply_reset();
        for (int k = 0; k < 5; k++) step(1'b0, 1'b1, 1'b0, 32'h0);
        n_vec++; if (count !== 3'd4) begin n_err++; $display("FAIL full_count: got %0d want 4", count); end
        n_vec++; if (iad !== 32'h10) begin n_err++; $display("FAIL full_iad: got %h want 00000010", iad); end
        n_vec++; if (u_dut.r_state !== ST_FULL) begin n_err++; $display("FAIL full_state: got %0d want %0d", u_dut.r_state, ST_FULL); end
        n_vec++; if (pc !== 32'h0 || ir !== mem_word(32'h0)) begin n_err++; $display("FAIL full_head: got pc=%h ir=%h want pc=0 ir=%h", pc, ir, mem_word(32'h0)); end
        step(1'b0, 1'b0, 1'b0, 32'h0);
        n_vec++; if (count !== 3'd4) begin n_err++; $display("FAIL full_pushpop_count: got %0d want 4", count); end
        n_vec++; if (pc !== 32'h4 || iad !== 32'h14) begin n_err++; $display("FAIL full_pushpop: got pc=%h iad=%h want 4/14", pc, iad); end
    endtask

    task automatic test_wait();
        for (int k = 1; k <= 3; k++) begin
            step(1'b1, 1'b0, 1'b0, 32'h0);
            n_vec++; if (iad !== 32'h14 || count !== 3'(4 - k)) begin n_err++; $display("FAIL wait_hold: got iad=%h count=%0d want 14/%0d", iad, count, 4 - k); end
        end
        step(1'b0, 1'b0, 1'b0, 32'h0);
        n_vec++; if (iad !== 32'h18 || count !== 3'd1) begin n_err++; $display("FAIL wait_resume: got iad=%h count=%0d want 18/1", iad, count); end
        n_vec++; if (perf_wait_cnt !== (PERF ? 32'd3 : 32'd0)) begin n_err++; $display("FAIL wait_perf: got %0d want %0d", perf_wait_cnt, PERF ? 3 : 0); end
    endtask

    task automatic test_redirect();
        apply_reset();
        for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 1'b0, 32'h0);
        n_vec++; if (count !== 3'd3) begin n_err++; $display("FAIL redir_pre_count: got %0d want 3", count); end
        step(1'b0, 1'b1, 1'b1, 32'h0000_0102);
        n_vec++; if (count !== 3'd0 || ir_valid !== 1'b0) begin n_err++; $display("FAIL redir_flush: got count=%0d v=%b want 0/0", count, ir_valid); end
        n_vec++; if (ir !== 32'h0000_0013 || iad !== 32'h100) begin n_err++; $display("FAIL redir_ir_iad: got ir=%h iad=%h want 00000013/00000100", ir, iad); end
        n_vec++; if (perf_flush_cnt !== (PERF ? 32'd3 : 32'd0)) begin n_err++; $display("FAIL redir_perf: got %0d want %0d", perf_flush_cnt, PERF ? 3 : 0); end
    endtask

    task automatic test_redirect_full_pop();
        apply_reset();
        for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b1, 32'h0000_0200);
        n_vec++; if (count !== 3'd0 || iad !== 32'h200) begin n_err++; $display("FAIL redir_full: got count=%0d iad=%h want 0/200", count, iad); end
        step(1'b0, 1'b0, 1'b0, 32'h0);
        n_vec++; if (count !== 3'd1 || pc !== 32'h200) begin n_err++; $display("FAIL redir_full_next: got count=%0d pc=%h want 1/200", count, pc); end
    endtask

    task automatic test_wrap();
        step(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        n_vec++; if (count !== 3'd2 || pc !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_first: got count=%0d pc=%h want 2/fffffffc", count, pc); end
        n_vec++; if (pc4 !== 32'h0 || iad !== 32'h4) begin n_err++; $display("FAIL wrap_pc4_iad: got pc4=%h iad=%h want 0/4", pc4, iad); end
        step(1'b0, 1'b0, 1'b0, 32'h0);
        n_vec++; if (pc !== 32'h0 || iad !== 32'h8) begin n_err++; $display("FAIL wrap_second: got pc=%h iad=%h want 0/8", pc, iad); end
    endtask

    task automatic test_back_to_back();
        logic a, s, r;
        apply_reset();
        for (int k = 0; k < 300; k++) begin
            a = ($urandom_range(0, 3) == 0);
            s = ($urandom_range(0, 9) < 3);
            r = ($urandom_range(0, 31) == 0);
            step(a, s, r, $urandom);
            n_vec++; if (count !== 3'(sb.size()) || ir_valid !== (sb.size() != 0)) begin n_err++; $display("FAIL rand_count @%0d: got %0d/%b want %0d", k, count, ir_valid, sb.size()); end
            n_vec++; if (ir !== exp_ir() || pc !== exp_pc() || pc4 !== exp_pc4()) begin n_err++; $display("FAIL rand_head @%0d: got %h/%h/%h want %h/%h/%h", k, ir, pc, pc4, exp_ir(), exp_pc(), exp_pc4()); end
            n_vec++; if (iad !== m_pc) begin n_err++; $display("FAIL rand_iad @%0d: got %h want %h", k, iad, m_pc); end
            n_vec++; if (perf_wait_cnt !== (PERF ? m_wait : 32'd0) || perf_flush_cnt !== (PERF ? m_flush : 32'd0)) begin n_err++; $display("FAIL rand_perf @%0d: got %0d/%0d want %0d/%0d", k, perf_wait_cnt, perf_flush_cnt, PERF ? m_wait : 0, PERF ? m_flush : 0); end
        end
    endtask

    initial begin
        model_reset();
        #12 rst_n = 1'b1;
        test_reset();
        test_stream();
        test_full();
        test_wait();
        test_redirect();
        test_redirect_full_pop();
        test_wrap();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
